// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder/subtractor.
package add_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational WIDTH-bit ripple-carry adder slice; zero latency, no flow control.
module add_chunk
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Carry is a block-local variable so the ripple is not a self-dependent vector.
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/add_seq_n.sv
// Multi-cycle add/sub, CHUNK bits per clock; done pulses WIDTH/CHUNK cycles after start.
// No queueing: start is only accepted in IDLE or DONE and is dropped while busy.
module add_seq_n
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK > WIDTH) begin : g_bad_params
        $fatal(1, "add_seq_n: WIDTH must be a multiple of CHUNK and CHUNK <= WIDTH");
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] bx_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nxt;
    logic            carry;
    logic [31:0]     base;
    logic [CHUNK-1:0] ch_a;
    logic [CHUNK-1:0] ch_b;
    logic [CHUNK-1:0] ch_sum;
    logic            ch_cout;

    assign base = 32'(cnt) * CHUNK;
    assign ch_a = a_r[base +: CHUNK];
    assign ch_b = bx_r[base +: CHUNK];

    add_chunk #(.WIDTH(CHUNK)) u_chunk (
        .a    (ch_a),
        .b    (ch_b),
        .cin  (carry),
        .sum  (ch_sum),
        .cout (ch_cout)
    );

    always_comb begin
        sum_nxt = sum_r;
        sum_nxt[base +: CHUNK] = ch_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_r   <= '0;
            bx_r  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtract is folded into the operands once, so RUN is sign-agnostic.
                        a_r   <= a;
                        bx_r  <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_r <= sum_nxt;
                    carry <= ch_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        cout  <= ch_cout;
                        ovf   <= (a_r[WIDTH-1] == bx_r[WIDTH-1]) &&
                                 (sum_nxt[WIDTH-1] != a_r[WIDTH-1]);
                        zero  <= ~|sum_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = sum_r;

endmodule

// File: tb/tb_add_seq_n.sv
// Scoreboard bench for add_seq_n at WIDTH/CHUNK = 8/4, 32/4 and 4/4.
module tb_add_seq_n;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;

    logic [2:0]  obusy, odone, ocout, oovf, ozero;
    logic [7:0]  sum8;
    logic [31:0] sum32;
    logic [3:0]  sum4;
    logic [31:0] osum [3];

    exp_t q [3][$];
    int   lat [3] = '{2, 8, 1};
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign osum[0] = {24'd0, sum8};
    assign osum[1] = sum32;
    assign osum[2] = {28'd0, sum4};

    add_seq_n #(.WIDTH(8), .CHUNK(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .busy(obusy[0]), .done(odone[0]), .sum(sum8), .cout(ocout[0]),
        .ovf(oovf[0]), .zero(ozero[0])
    );

    add_seq_n #(.WIDTH(32), .CHUNK(4)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(obusy[1]), .done(odone[1]), .sum(sum32), .cout(ocout[1]),
        .ovf(oovf[1]), .zero(ozero[1])
    );

    add_seq_n #(.WIDTH(4), .CHUNK(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub), .a(a[3:0]), .b(b[3:0]),
        .cin(cin), .busy(obusy[2]), .done(odone[2]), .sum(sum4), .cout(ocout[2]),
        .ovf(oovf[2]), .zero(ozero[2])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Drive one accepted start and record the hand-computed result.
    task automatic issue(input int d, input logic s, input logic [31:0] av, input logic [31:0] bv,
                         input logic c, input logic [31:0] es, input logic ec, input logic eo,
                         input logic ez);
        exp_t e;
        sub = s; a = av; b = bv; cin = c;
        start[d] = 1'b1;
        e.sum = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.cyc = cyc;
        q[d].push_back(e);
        @(negedge clk);
        start[d] = 1'b0;
        a = $urandom; b = $urandom;
        cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!odone[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("d%0d done_seen", d), 32'(odone[d]), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (odone[d]) begin
                    exp_t e;
                    chk($sformatf("d%0d done_expected", d), 32'(q[d].size() > 0), 32'd1);
                    if (q[d].size() > 0) begin
                        e = q[d].pop_front();
                        chk($sformatf("d%0d sum", d),     osum[d],          e.sum);
                        chk($sformatf("d%0d cout", d),    32'(ocout[d]),    32'(e.cout));
                        chk($sformatf("d%0d ovf", d),     32'(oovf[d]),     32'(e.ovf));
                        chk($sformatf("d%0d zero", d),    32'(ozero[d]),    32'(e.zero));
                        chk($sformatf("d%0d latency", d), 32'(cyc - e.cyc), 32'(lat[d] + 1));
                        chk($sformatf("d%0d busy_at_done", d), 32'(obusy[d]), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = '0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d reset_ctrl_flags", d),
                32'({obusy[d], odone[d], ocout[d], oovf[d], ozero[d]}), 32'd0);
            chk($sformatf("d%0d reset_sum", d), osum[d], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 8/4: add, carry-out to zero, back-to-back signed overflow
        issue(0, 1'b0, 32'h2D, 32'h1F, 1'b0, 32'h4C, 1'b0, 1'b0, 1'b0); wait_done(0);
        @(negedge clk);
        issue(0, 1'b0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1); wait_done(0);
        issue(0, 1'b0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0); wait_done(0);
        @(negedge clk);
        chk("w8 sum_held_idle", osum[0], 32'h80);
        chk("w8 ovf_held_idle", 32'(oovf[0]), 32'd1);

        // 8/4: subtract with borrow, signed overflow, borrow-in to zero
        issue(0, 1'b1, 32'h05, 32'h07, 1'b0, 32'hFE, 1'b0, 1'b0, 1'b0); wait_done(0);
        issue(0, 1'b1, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b0); wait_done(0);
        issue(0, 1'b1, 32'h10, 32'h0F, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1); wait_done(0);
        @(negedge clk);

        // 4/4: single RUN cycle
        issue(2, 1'b0, 32'h6, 32'h1, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0); wait_done(2);
        issue(2, 1'b0, 32'h7, 32'h1, 1'b0, 32'h8, 1'b0, 1'b1, 1'b0); wait_done(2);
        @(negedge clk);

        // 32/4: start pulsed during RUN must be ignored
        issue(1, 1'b0, 32'h2, 32'h0, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("w32 busy_in_run", 32'(obusy[1]), 32'd1);
        a = 32'hFFFF; b = 32'h1; start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        wait_done(1);
        repeat (12) @(negedge clk);

        // 32/4: reset in the middle of RUN aborts with no done
        issue(1, 1'b0, 32'h1234, 32'h1111, 1'b0, 32'h2345, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        q[1].delete();
        chk("w32 midrun_reset_ctrl_flags",
            32'({obusy[1], odone[1], ocout[1], oovf[1], ozero[1]}), 32'd0);
        chk("w32 midrun_reset_sum", osum[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("w32 no_done_after_abort", 32'(odone[1]), 32'd0);

        // 32/4: full carry chain and 32-bit signed overflow
        issue(1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1); wait_done(1);
        issue(1, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0); wait_done(1);
        repeat (5) @(negedge clk);

        for (int d = 0; d < 3; d++)
            chk($sformatf("d%0d outstanding", d), 32'(q[d].size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
